// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: widths, op codes and FSM states.
package mdu_pkg;

  localparam int MDU_WIDTH  = 32;
  localparam int ITERATIONS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate, used both for operand magnitude and result sign fixup.
module mdu_abs_neg #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic              negate,
  output logic [DATA_W-1:0] result
);

  assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply, restoring divide, 33-edge latency.
// Define MDU_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(ITERATIONS) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS);

  mdu_state_e state, stateNext;

  logic               accept, signedIn, lastStep, earlyDone;
  logic [WIDTH-1:0]   rsAbs, rtAbs;
  logic               isDiv, negResult, negRem, divZero;
  logic [WIDTH-1:0]   rsRaw, opB, rem, quo;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     divShifted, divTrial;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign accept   = (state == ST_IDLE) && start;
  assign signedIn = ~op[0];

  mdu_abs_neg #(.DATA_W(WIDTH)) uRsAbs (.value(rs), .negate(signedIn & rs[WIDTH-1]), .result(rsAbs));
  mdu_abs_neg #(.DATA_W(WIDTH)) uRtAbs (.value(rt), .negate(signedIn & rt[WIDTH-1]), .result(rtAbs));

`ifdef MDU_EARLY_OUT_EN
  assign earlyDone = !isDiv && (count != '0) && (opB == '0);
`else
  assign earlyDone = 1'b0;
`endif

  assign lastStep = (count == LAST_COUNT) || earlyDone;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (start) stateNext = ST_RUN;
      ST_RUN:  if (lastStep) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Restoring divide step: shift next dividend bit into the remainder and trial-subtract.
  assign divShifted = {rem, quo[WIDTH-1]};
  assign divTrial   = divShifted - {1'b0, opB};

  // Working registers carry no reset; they are fully reloaded on every accepted start.
  always_ff @(posedge clock) begin
    if (accept) begin
      isDiv     <= op[1];
      negResult <= signedIn & (rs[WIDTH-1] ^ rt[WIDTH-1]);
      negRem    <= signedIn & rs[WIDTH-1];
      divZero   <= (rt == '0);
      rsRaw     <= rs;
      count     <= '0;
      mcand     <= {{WIDTH{1'b0}}, rsAbs};
      opB       <= rtAbs;
      acc       <= '0;
      rem       <= '0;
      quo       <= rsAbs;
    end else if ((state == ST_RUN) && !lastStep) begin
      count <= count + 1'b1;
      if (isDiv) begin
        if (!divTrial[WIDTH]) begin
          rem <= divTrial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= divShifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (opB[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        opB   <= opB >> 1;
      end
    end
  end

  mdu_abs_neg #(.DATA_W(2*WIDTH)) uProdFix (.value(acc), .negate(negResult), .result(prodFix));
  mdu_abs_neg #(.DATA_W(WIDTH))   uQuoFix  (.value(quo), .negate(negResult), .result(quoFix));
  mdu_abs_neg #(.DATA_W(WIDTH))   uRemFix  (.value(rem), .negate(negRem),    .result(remFix));

  // Result stage: sign fixup lands in hi/lo on the final RUN edge and holds until the next result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= 1'b0;
    end else if ((state == ST_RUN) && lastStep) begin
      if (isDiv && divZero) begin
        hi          <= rsRaw;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end else if (isDiv) begin
        hi <= remFix;
        lo <= quoFix;
      end else begin
        {hi, lo} <= prodFix;
      end
    end
  end

endmodule
